mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Memory controller directly downstream of the load/store queue and the instruction fetch unit. It arbitrates their requests onto the single byte-wide RAM port.
- Serialises 1/2/4-byte little-endian reads and writes, byte by byte. Returns load data right-aligned and zero-extended; sign extension belongs to the LS queue.
- Stalls writes to the IO region while the IO buffer is full.

Parameters:
- ADDR_WIDTH, 32, RAM and request address width.
- DATA_WIDTH, 32, request data width.
- IO_ADDR_BITS, 2'b11, value of addr[17:16] that marks the IO region.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ena  in  1  global enable; when low, state is frozen and mem_wr is 0.
- in_rollback  in  1  misbranch flush.
- in_ls_ena  in  1  one-cycle LS request pulse; the fields below are sampled in the same cycle.
- in_ls_iswrite  in  1  1 = store.
- in_ls_addr  in  ADDR_WIDTH  byte address.
- in_ls_data  in  DATA_WIDTH  store data, low bytes used.
- in_ls_size  in  3  byte count: 1, 2 or 4.
- out_ls_ready  out  1  one-cycle completion pulse.
- out_ls_data  out  DATA_WIDTH  load result, zero-extended; 0 for stores.
- in_if_ena  in  1  one-cycle fetch request pulse.
- in_if_addr  in  ADDR_WIDTH  word address of the fetch.
- out_if_ready  out  1  one-cycle fetch completion pulse.
- out_if_data  out  32  fetched instruction.
- mem_din  in  8  RAM read byte, valid one cycle after mem_a.
- mem_dout  out  8  RAM write byte.
- mem_a  out  ADDR_WIDTH  RAM address.
- mem_wr  out  1  RAM write strobe.
- io_buffer_full  in  1  IO sink cannot accept a byte.

Behaviour:
- Reset: all outputs are 0 immediately (asynchronous); state IDLE; both pending latches cleared.
- Request latching: each of in_ls_ena and in_if_ena sets its own pending latch, capturing address, size and data. At most one request per source is outstanding. A second pulse from a source before its ready pulse is a protocol error and is ignored.
- States: IDLE, READ, WRITE. Counter cnt runs from 0 to size.
- IDLE transitions:
  - LS pending → READ or WRITE. LS has priority.
  - Else IF pending → READ with size 4.
  - A pulse arriving in IDLE may be served in the same cycle it is latched.
- READ:
  - mem_a = base + cnt is presented on successive cycles.
  - The byte on mem_din is captured into bits [8k+7:8k] one cycle after its address.
  - After the last byte is captured, the ready pulse and data are registered, then the block returns to IDLE.
  - Timing: request sampled at cycle 0 → mem_a at cycles 1..n → bytes captured at cycles 2..n+1 → ready visible at cycle n+2.
- WRITE:
  - mem_wr = 1, mem_a = base + k, mem_dout = data[8k+7:8k] in cycles 1..n.
  - out_ls_ready is visible at cycle n+1.
  - IO stall: if addr[17:16] == IO_ADDR_BITS and io_buffer_full is 1, mem_wr is 0 and cnt holds. The byte is re-driven when io_buffer_full drops.
- mem_wr is 0 in every non-WRITE cycle.
- ena low: state, cnt and the data accumulator hold; mem_wr is 0. On resume, the address of the first uncaptured byte is re-presented before capture continues.
- in_rollback:
  - Clears the IF pending latch, and aborts an IF or LS read in flight, with no ready pulse.
  - An LS store in flight, or a pending LS store, completes normally.
  - Rollback together with a new in_ls_ena that is a store: the store is latched. A load in the same case is dropped.
- Ready pulses last exactly one cycle. out_ls_ready and out_if_ready are never high in the same cycle.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. Misalignment is not checked.

Decomposition:
- Shared constants package:
  - state encodings
  - IO_ADDR_BITS
  - size encodings 1/2/4
  - ZERO_DATA
- One natural sub-module, mem_byte_serializer: cnt, address increment, byte capture/shift and the IO stall. mem_ctrl keeps arbitration, the pending latches and rollback.

Test Plan:
- LW: LS read of addr 0x100 (RAM bytes 0x11,0x22,0x33,0x44), size 4 → out_ls_ready at cycle 6, out_ls_data 0x44332211.
- SB: data 0xABCD12EF to addr 0x200, size 1 → mem_wr=1 in cycle 1 only, mem_a 0x200, mem_dout 0xEF, ready at cycle 2.
- Simultaneous IF 0x0 and LS LH 0x10 → LS serviced first (ready at cycle 4, 0x0000XXXX zero-extended). IF ready later with the correct word; IF mem_a starts only after LS completes.
- IO stall: SB to 0x30000 with io_buffer_full high for 3 cycles → mem_wr stays 0 for 3 cycles, then one write, then ready.
- Rollback during an IF read at cnt=2 → no out_if_ready, IDLE next cycle. Rollback during SW at cnt=1 → all 4 bytes are written and out_ls_ready fires.
- rst low mid-write → mem_wr is 0 asynchronously. After release, the next request is served from IDLE with no stale pending request.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and constants for the memory controller and its byte serializer.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  typedef enum logic {
    SRC_LS = 1'b0,
    SRC_IF = 1'b1
  } src_t;

  localparam logic [1:0]  IO_REGION = 2'b11;

  localparam logic [2:0]  SIZE_BYTE = 3'd1;
  localparam logic [2:0]  SIZE_HALF = 3'd2;
  localparam logic [2:0]  SIZE_WORD = 3'd4;

  localparam logic [31:0] ZERO_DATA = 32'h0;

endpackage

// File: rtl/mem_ctrl_byte_serializer.sv
// Walks one 1/2/4-byte access over the byte-wide RAM port: address stepping,
// little-endian byte capture for reads, byte drive and IO back-pressure for writes.
module mem_byte_serializer
  import mem_ctrl_pkg::*;
#(
  parameter int         ADDR_WIDTH   = 32,
  parameter int         DATA_WIDTH   = 32,
  parameter logic [1:0] IO_ADDR_BITS = IO_REGION
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  state_t                state,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [DATA_WIDTH-1:0] start_data,
  input  logic [2:0]            start_size,
  input  logic [7:0]            mem_din,
  input  logic                  io_buffer_full,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [7:0]            mem_dout,
  output logic                  mem_wr,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [ADDR_WIDTH-1:0] base;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_next;
  logic [2:0]            size;
  logic [2:0]            cnt;
  logic                  resume;
  logic                  rd;
  logic                  wr;
  logic                  io_stall;
  logic                  wr_go;
  logic                  capture;

  assign rd       = (state == ST_READ);
  assign wr       = (state == ST_WRITE);
  assign io_stall = (base[17:16] == IO_ADDR_BITS) && io_buffer_full;
  assign wr_go    = wr && ena && !io_stall;
  // In READ, cnt = k captures byte k-1; the cycle after a freeze re-presents that byte's address.
  assign capture  = rd && ena && !resume && (cnt != 3'd0);

  assign mem_wr   = wr_go;
  assign mem_a    = base + ADDR_WIDTH'(resume ? cnt - 3'd1 : cnt);
  assign mem_dout = 8'(wdata >> {cnt, 3'b000});
  assign done     = (wr_go && (cnt == size - 3'd1)) || (capture && (cnt == size));
  assign rdata    = acc_next;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    acc_next = acc;
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      if (capture && (cnt == 3'(i + 1))) acc_next[8*i +: 8] = mem_din;
    end
  end

  // NOTE: the data registers are reset too (not only control), because mem_a and mem_dout must read 0 during reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base   <= '0;
      wdata  <= '0;
      acc    <= '0;
      size   <= '0;
      cnt    <= '0;
      resume <= 1'b0;
    end else if (start) begin
      base   <= start_addr;
      wdata  <= start_data;
      size   <= start_size;
      cnt    <= '0;
      acc    <= '0;
      resume <= 1'b0;
    end else if (!ena) begin
      if (rd && (cnt != 3'd0)) resume <= 1'b1;
    end else if (resume) begin
      resume <= 1'b0;
    end else begin
      if ((rd && (cnt != size)) || wr_go) cnt <= cnt + 3'd1;
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates load/store and fetch requests onto the byte-wide RAM port; LS wins,
// rollback flushes fetches and loads but lets stores finish.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int         ADDR_WIDTH   = 32,
  parameter int         DATA_WIDTH   = 32,
  parameter logic [1:0] IO_ADDR_BITS = IO_REGION
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  in_rollback,
  input  logic                  in_ls_ena,
  input  logic                  in_ls_iswrite,
  input  logic [ADDR_WIDTH-1:0] in_ls_addr,
  input  logic [DATA_WIDTH-1:0] in_ls_data,
  input  logic [2:0]            in_ls_size,
  output logic                  out_ls_ready,
  output logic [DATA_WIDTH-1:0] out_ls_data,
  input  logic                  in_if_ena,
  input  logic [ADDR_WIDTH-1:0] in_if_addr,
  output logic                  out_if_ready,
  output logic [31:0]           out_if_data,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  state_t                state;
  src_t                  owner;
  logic                  ls_pend, ls_wr, if_pend;
  logic [ADDR_WIDTH-1:0] ls_addr, if_addr;
  logic [DATA_WIDTH-1:0] ls_data;
  logic [2:0]            ls_size;

  logic                  ls_busy, if_busy, ls_new, if_new, ls_want, if_want;
  logic                  launch_ls, launch_if, start, done;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_ls_addr, sel_if_addr;
  logic [DATA_WIDTH-1:0] sel_data, rdata;
  logic [2:0]            sel_size;

  assign ls_busy = ls_pend || ((state != ST_IDLE) && (owner == SRC_LS));
  assign if_busy = if_pend || ((state != ST_IDLE) && (owner == SRC_IF));
  // A repeat pulse from a busy source is ignored; rollback drops loads and fetches but keeps stores.
  assign ls_new  = in_ls_ena && !ls_busy && !(in_rollback && !in_ls_iswrite);
  assign if_new  = in_if_ena && !if_busy && !in_rollback;
  assign ls_want = (ls_pend && !(in_rollback && !ls_wr)) || ls_new;
  assign if_want = (if_pend && !in_rollback) || if_new;

  assign sel_wr      = ls_pend ? ls_wr   : in_ls_iswrite;
  assign sel_ls_addr = ls_pend ? ls_addr : in_ls_addr;
  assign sel_data    = ls_pend ? ls_data : in_ls_data;
  assign sel_size    = ls_pend ? ls_size : in_ls_size;
  assign sel_if_addr = if_pend ? if_addr : in_if_addr;

  assign launch_ls = ena && (state == ST_IDLE) && ls_want;
  assign launch_if = ena && (state == ST_IDLE) && !ls_want && if_want;
  assign start     = launch_ls || launch_if;

  mem_byte_serializer #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .IO_ADDR_BITS(IO_ADDR_BITS)
  ) u_ser (
    .clk           (clk),
    .rst           (rst),
    .ena           (ena),
    .state         (state),
    .start         (start),
    .start_addr    (launch_ls ? sel_ls_addr : sel_if_addr),
    .start_data    (sel_data),
    .start_size    (launch_ls ? sel_size : SIZE_WORD),
    .mem_din       (mem_din),
    .io_buffer_full(io_buffer_full),
    .mem_a         (mem_a),
    .mem_dout      (mem_dout),
    .mem_wr        (mem_wr),
    .done          (done),
    .rdata         (rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      owner        <= SRC_LS;
      ls_pend      <= 1'b0;
      ls_wr        <= 1'b0;
      ls_addr      <= '0;
      ls_data      <= '0;
      ls_size      <= '0;
      if_pend      <= 1'b0;
      if_addr      <= '0;
      out_ls_ready <= 1'b0;
      out_ls_data  <= '0;
      out_if_ready <= 1'b0;
      out_if_data  <= '0;
    end else begin
      out_ls_ready <= 1'b0;
      out_if_ready <= 1'b0;
      if (ena) begin
        ls_pend <= ls_want && !launch_ls;
        if_pend <= if_want && !launch_if;
        if (ls_new) begin
          ls_wr   <= in_ls_iswrite;
          ls_addr <= in_ls_addr;
          ls_data <= in_ls_data;
          ls_size <= in_ls_size;
        end
        if (if_new) if_addr <= in_if_addr;
        case (state)
          ST_IDLE: begin
            if (launch_ls) begin
              state <= sel_wr ? ST_WRITE : ST_READ;
              owner <= SRC_LS;
            end else if (launch_if) begin
              state <= ST_READ;
              owner <= SRC_IF;
            end
          end
          ST_READ: begin
            if (in_rollback) begin
              state <= ST_IDLE;
            end else if (done) begin
              state <= ST_IDLE;
              if (owner == SRC_LS) begin
                out_ls_ready <= 1'b1;
                out_ls_data  <= rdata;
              end else begin
                out_if_ready <= 1'b1;
                out_if_data  <= rdata[31:0];
              end
            end
          end
          ST_WRITE: begin
            if (done) begin
              state        <= ST_IDLE;
              out_ls_ready <= 1'b1;
              out_ls_data  <= DATA_WIDTH'(ZERO_DATA);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus pushes expected ready pulses, a negedge
// monitor pops and compares source, arrival cycle and data.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b1;
  logic        in_rollback = 1'b0;
  logic        in_ls_ena = 1'b0;
  logic        in_ls_iswrite = 1'b0;
  logic [31:0] in_ls_addr = '0;
  logic [31:0] in_ls_data = '0;
  logic [2:0]  in_ls_size = '0;
  logic        out_ls_ready;
  logic [31:0] out_ls_data;
  logic        in_if_ena = 1'b0;
  logic [31:0] in_if_addr = '0;
  logic        out_if_ready;
  logic [31:0] out_if_data;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .ena(ena), .in_rollback(in_rollback),
    .in_ls_ena(in_ls_ena), .in_ls_iswrite(in_ls_iswrite), .in_ls_addr(in_ls_addr),
    .in_ls_data(in_ls_data), .in_ls_size(in_ls_size),
    .out_ls_ready(out_ls_ready), .out_ls_data(out_ls_data),
    .in_if_ena(in_if_ena), .in_if_addr(in_if_addr),
    .out_if_ready(out_if_ready), .out_if_data(out_if_data),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          is_if;
    logic [31:0] data;
    int          cyc;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   next_id = 0;

  logic [7:0] ram [logic [31:0]];

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  always @(posedge clk) begin
    mem_din <= ram_rd(mem_a);
    if (mem_wr) ram[mem_a] = mem_dout;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_rsp(input bit is_if, input logic [31:0] d, input int c);
    exp_q.push_back('{is_if: is_if, data: d, cyc: c, id: next_id});
    next_id++;
  endtask

  always @(negedge clk) begin
    if (rst && (out_ls_ready || out_if_ready)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", {62'd0, out_ls_ready, out_if_ready}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("ready_src#%0d", mon_e.id), {62'd0, out_ls_ready, out_if_ready},
              mon_e.is_if ? 64'd1 : 64'd2);
        check($sformatf("ready_cycle#%0d", mon_e.id), 64'(cyc), 64'(mon_e.cyc));
        check($sformatf("ready_data#%0d", mon_e.id),
              mon_e.is_if ? 64'(out_if_data) : 64'(out_ls_data), 64'(mon_e.data));
      end
    end
  end

  // Advance to just after the rising edge that starts cycle c; request pulses last one cycle.
  task automatic drive_at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
      in_ls_ena   = 1'b0;
      in_if_ena   = 1'b0;
      in_rollback = 1'b0;
    end
  endtask

  task automatic sample_at(input int c);
    drive_at(c);
    @(negedge clk);
  endtask

  task automatic issue_ls(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] s);
    in_ls_ena     = 1'b1;
    in_ls_iswrite = wr;
    in_ls_addr    = a;
    in_ls_data    = d;
    in_ls_size    = s;
  endtask

  task automatic issue_if(input logic [31:0] a);
    in_if_ena  = 1'b1;
    in_if_addr = a;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      drive_at(cyc + 1);
      n++;
    end
    check({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    drive_at(cyc + 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int t0;
  int t1;

  initial begin
    ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
    ram[32'h10]  = 8'h5A; ram[32'h11]  = 8'hA5; ram[32'h12]  = 8'hFF;
    ram[32'h0]   = 8'h13; ram[32'h1]   = 8'h00; ram[32'h2]   = 8'h50; ram[32'h3]   = 8'h00;

    // Reset values
    #2;
    check("reset_mem", {mem_wr, mem_dout, mem_a}, 64'd0);
    check("reset_ready", {out_ls_ready, out_if_ready}, 64'd0);
    check("reset_data", {out_ls_data, out_if_data}, 64'd0);
    drive_at(2);
    rst = 1'b1;

    // LW 0x100 with an ignored second LS pulse while busy
    drive_at(4);
    t0 = cyc;
    issue_ls(1'b0, 32'h100, 32'h0, SIZE_WORD);
    expect_rsp(1'b0, 32'h4433_2211, t0 + 6);
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        drive_at(t0 + 2);
        issue_ls(1'b0, 32'h200, 32'h0, SIZE_BYTE);
      end
      sample_at(t0 + 1 + k);
      check($sformatf("lw_mem_a%0d", k), 64'(mem_a), 64'(32'h100 + k));
    end
    drain("lw");

    // SB outside IO region: io_buffer_full must not stall it
    drive_at(cyc + 1);
    t0 = cyc;
    io_buffer_full = 1'b1;
    issue_ls(1'b1, 32'h200, 32'hABCD_12EF, SIZE_BYTE);
    expect_rsp(1'b0, 32'h0, t0 + 2);
    sample_at(t0 + 1);
    check("sb_cycle1", {mem_wr, mem_dout, mem_a}, {23'd0, 1'b1, 8'hEF, 32'h200});
    sample_at(t0 + 2);
    check("sb_cycle2_wr", 64'(mem_wr), 64'd0);
    drain("sb");
    io_buffer_full = 1'b0;
    check("sb_ram", 64'(ram_rd(32'h200)), 64'hEF);

    // Simultaneous IF and LH: LS first, IF afterwards
    drive_at(cyc + 1);
    t0 = cyc;
    issue_ls(1'b0, 32'h10, 32'h0, SIZE_HALF);
    issue_if(32'h0);
    expect_rsp(1'b0, 32'h0000_A55A, t0 + 4);
    expect_rsp(1'b1, 32'h0050_0013, t0 + 10);
    sample_at(t0 + 1);
    check("arb_ls_first", 64'(mem_a), 64'h10);
    sample_at(t0 + 5);
    check("arb_if_start", 64'(mem_a), 64'h0);
    drain("arb");

    // IO stall: three stalled cycles, then one write
    drive_at(cyc + 1);
    t0 = cyc;
    io_buffer_full = 1'b1;
    issue_ls(1'b1, 32'h3_0000, 32'h0000_0077, SIZE_BYTE);
    expect_rsp(1'b0, 32'h0, t0 + 5);
    for (int k = 1; k <= 3; k++) begin
      sample_at(t0 + k);
      check($sformatf("io_stall%0d", k), 64'(mem_wr), 64'd0);
    end
    drive_at(t0 + 4);
    io_buffer_full = 1'b0;
    sample_at(t0 + 4);
    check("io_write", {mem_wr, mem_dout, mem_a}, {23'd0, 1'b1, 8'h77, 32'h3_0000});
    drain("io");
    check("io_ram", 64'(ram_rd(32'h3_0000)), 64'h77);

    // Rollback aborts IF at cnt=2; a store issued with the rollback is latched
    drive_at(cyc + 1);
    t0 = cyc;
    issue_if(32'h0);
    drive_at(t0 + 3);
    in_rollback = 1'b1;
    issue_ls(1'b1, 32'h500, 32'h0000_0055, SIZE_BYTE);
    expect_rsp(1'b0, 32'h0, t0 + 6);
    sample_at(t0 + 5);
    check("rb_if_store", {mem_wr, mem_a}, {31'd0, 1'b1, 32'h500});
    drain("rb_if");
    check("rb_if_ram", 64'(ram_rd(32'h500)), 64'h55);

    // Rollback during SW at cnt=1: store completes
    drive_at(cyc + 1);
    t0 = cyc;
    issue_ls(1'b1, 32'h300, 32'hDEAD_BEEF, SIZE_WORD);
    drive_at(t0 + 2);
    in_rollback = 1'b1;
    expect_rsp(1'b0, 32'h0, t0 + 5);
    drain("rb_sw");
    check("rb_sw_ram", 64'({ram_rd(32'h303), ram_rd(32'h302), ram_rd(32'h301), ram_rd(32'h300)}),
          64'hDEAD_BEEF);

    // ena low for two cycles mid-read; the uncaptured byte's address is re-presented
    drive_at(cyc + 1);
    t0 = cyc;
    issue_ls(1'b0, 32'h100, 32'h0, SIZE_WORD);
    expect_rsp(1'b0, 32'h4433_2211, t0 + 9);
    drive_at(t0 + 3);
    ena = 1'b0;
    sample_at(t0 + 3);
    check("ena_low_wr", 64'(mem_wr), 64'd0);
    drive_at(t0 + 5);
    ena = 1'b1;
    sample_at(t0 + 5);
    check("ena_resume_a", 64'(mem_a), 64'h101);
    sample_at(t0 + 6);
    check("ena_continue_a", 64'(mem_a), 64'h102);
    drain("ena");

    // Asynchronous reset mid-write, then a clean request
    drive_at(cyc + 1);
    t0 = cyc;
    issue_ls(1'b1, 32'h400, 32'h1234_5678, SIZE_WORD);
    drive_at(t0 + 2);
    check("pre_reset_wr", 64'(mem_wr), 64'd1);
    rst = 1'b0;
    #1;
    check("async_reset_mem", {mem_wr, mem_dout, mem_a}, 64'd0);
    drive_at(t0 + 4);
    rst = 1'b1;
    drive_at(t0 + 5);
    t1 = cyc;
    issue_ls(1'b0, 32'h101, 32'h0, SIZE_BYTE);
    expect_rsp(1'b0, 32'h0000_0022, t1 + 3);
    drain("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
